// File: rtl/imm_extender_pipe.sv
// Pipelined immediate generator: four extension formats feeding a 2-entry
// valid/ready skid buffer with a registered in_ready.
module imm_extender_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       occupancy
);

  // state | meaning
  // EMPTY | no entries buffered, head/tail don't care
  // ONE   | head holds the oldest entry
  // FULL  | head oldest, tail next; upstream is stalled
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [OUT_W-1:0] head, head_nxt;
  logic [OUT_W-1:0] tail, tail_nxt;
  logic [OUT_W-1:0] sext, ext;
  logic             push, pop;

  always_comb begin
    sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    ext  = sext;
    case (in_mode)
      2'b00:   ext = sext;
      2'b01:   ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
      2'b10:   ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
      default: ext = {sext[OUT_W-3:0], 2'b00};
    endcase
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    case (state)
      EMPTY: begin
        if (push) begin
          head_nxt  = ext;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_nxt = ext;
        end else if (push) begin
          tail_nxt  = ext;
          state_nxt = FULL;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen
        if (pop) begin
          head_nxt  = tail;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= EMPTY;
      head     <= '0;
      tail     <= '0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      head     <= head_nxt;
      tail     <= tail_nxt;
      in_ready <= (state_nxt != FULL);
    end
  end

  assign out_valid = (state != EMPTY);
  assign out_data  = out_valid ? head : '0;
  assign occupancy = state;

endmodule

// File: tb/tb_imm_extender_pipe.sv
// Self-checking bench for imm_extender_pipe: scoreboard on the 16/32 instance
// plus directed checks on a 12/24 instance.
module tb_imm_extender_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  logic        v12, r12, ov12, or12;
  logic [11:0] imm12;
  logic [1:0]  mode12;
  logic [23:0] od12;
  logic [1:0]  occ12;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  imm_extender_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  imm_extender_pipe #(.IN_W(12), .OUT_W(24)) dut12 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v12), .in_ready(r12), .in_imm(imm12), .in_mode(mode12),
    .out_valid(ov12), .out_ready(or12), .out_data(od12),
    .occupancy(occ12)
  );

  function automatic logic [31:0] ref16(input logic [15:0] imm, input logic [1:0] m);
    logic [31:0] s;
    s = imm[15] ? (32'hFFFF0000 | {16'h0, imm}) : {16'h0, imm};
    case (m)
      2'b00:   return s;
      2'b01:   return {16'h0, imm};
      2'b10:   return {imm, 16'h0};
      default: return s << 2;
    endcase
  endfunction

  // Inputs change only #1 after posedge, so values at negedge are what the next edge sees.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow got %h required no output", out_data);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL sb_order got %h required %h", out_data, e);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(ref16(in_imm, in_mode));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    cyc();
    n_checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain got %0d left valid=%b required 0 left valid=0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'b00; out_ready = 1'b0;
    cyc();
    cyc();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b vld=%b occ=%0d data=%h required 1 0 0 0",
               in_ready, out_valid, occupancy, out_data);
    end
    in_valid = 1'b0;
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_modes();
    logic [15:0] vi[6] = '{16'hF000, 16'h0FFF, 16'hF000, 16'h1234, 16'hFFFF, 16'h0004};
    logic [1:0]  vm[6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    logic [31:0] ve[6] = '{32'hFFFFF000, 32'h00000FFF, 32'h0000F000, 32'h12340000,
                           32'hFFFFFFFC, 32'h00000010};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_imm = vi[i]; in_mode = vm[i];
      cyc();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== ve[i]) begin
        n_fail++;
        $display("FAIL mode_vec%0d got vld=%b data=%h required 1 %h", i, out_valid, out_data, ve[i]);
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_mode = 2'b00;
    in_valid = 1'b1; in_imm = 16'h0001;
    cyc();
    in_imm = 16'h0002;
    cyc();
    in_imm = 16'h0003;
    n_checks++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_data !== 32'h1) begin
      n_fail++;
      $display("FAIL bp_full got rdy=%b occ=%0d data=%h required 0 2 00000001", in_ready, occupancy, out_data);
    end
    cyc();
    cyc();
    n_checks++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_data !== 32'h1) begin
      n_fail++;
      $display("FAIL bp_hold got rdy=%b occ=%0d data=%h required 0 2 00000001", in_ready, occupancy, out_data);
    end
    out_ready = 1'b1;
    cyc();
    n_checks++;
    if (in_ready !== 1'b1 || occupancy !== 2'd1 || out_data !== 32'h2) begin
      n_fail++;
      $display("FAIL bp_first_pop got rdy=%b occ=%0d data=%h required 1 1 00000002", in_ready, occupancy, out_data);
    end
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (occupancy !== 2'd1 || out_data !== 32'h3) begin
      n_fail++;
      $display("FAIL bp_push_pop got occ=%0d data=%h required 1 00000003", occupancy, out_data);
    end
    drain();
  endtask

  task automatic test_stream();
    int bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_imm   = 16'($urandom);
      in_mode  = 2'($urandom_range(0, 3));
      cyc();
      if (in_ready !== 1'b1 || occupancy == 2'd2) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stream_ready got %0d bad cycles required 0", bad);
    end
    drain();
  endtask

  task automatic test_random_toggle();
    int bad = 0;
    logic acc;
    in_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_imm   = 16'($urandom);
        in_mode  = 2'($urandom_range(0, 3));
      end
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      cyc();
      if (acc) in_valid = 1'b0;
      if (occupancy > 2'd2 || (out_valid !== (occupancy != 2'd0))) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL toggle_occ got %0d bad cycles required 0", bad);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_mode = 2'b00;
    in_valid = 1'b1; in_imm = 16'h0011;
    cyc();
    in_imm = 16'h0022;
    cyc();
    n_checks++;
    if (occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL rst_pre_full got occ=%0d required 2", occupancy);
    end
    reset_n = 1'b0;
    in_imm = 16'h0033;
    cyc();
    reset_n = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid got vld=%b data=%h occ=%0d rdy=%b required 0 0 0 1",
               out_valid, out_data, occupancy, in_ready);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_imm = 16'h8000; in_mode = 2'b00;
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFF8000) begin
      n_fail++;
      $display("FAIL rst_after got vld=%b data=%h required 1 ffff8000", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_narrow();
    logic [11:0] vi[4] = '{12'h800, 12'h7FF, 12'hABC, 12'h001};
    logic [1:0]  vm[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [23:0] ve[4] = '{24'hFFF800, 24'h0007FF, 24'hABC000, 24'h000004};
    or12 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v12 = 1'b1; imm12 = vi[i]; mode12 = vm[i];
      cyc();
      v12 = 1'b0;
      n_checks++;
      if (ov12 !== 1'b1 || od12 !== ve[i] || occ12 !== 2'd1) begin
        n_fail++;
        $display("FAIL narrow_vec%0d got vld=%b data=%h occ=%0d required 1 %h 1",
                 i, ov12, od12, occ12, ve[i]);
      end
      cyc();
    end
    or12 = 1'b0;
    v12 = 1'b1; imm12 = 12'h001; mode12 = 2'b00;
    cyc();
    imm12 = 12'h002;
    cyc();
    v12 = 1'b0;
    n_checks++;
    if (r12 !== 1'b0 || occ12 !== 2'd2 || od12 !== 24'h000001) begin
      n_fail++;
      $display("FAIL narrow_full got rdy=%b occ=%0d data=%h required 0 2 000001", r12, occ12, od12);
    end
    or12 = 1'b1;
    cyc();
    n_checks++;
    if (od12 !== 24'h000002 || r12 !== 1'b1) begin
      n_fail++;
      $display("FAIL narrow_order got data=%h rdy=%b required 000002 1", od12, r12);
    end
    cyc();
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
    v12 = 1'b0; imm12 = '0; mode12 = '0; or12 = 1'b0;
    test_reset();
    test_modes();
    test_backpressure();
    test_stream();
    test_random_toggle();
    test_reset_mid();
    test_narrow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_extender_pipe.md
# imm_extender_pipe

Parametrised, pipelined immediate generator that replaces the purely combinational 16-to-32 sign extender in the datapath. It takes an IN_W-bit immediate field plus a 2-bit mode from decode and produces an OUT_W-bit operand in one of four extension formats. It is registered behind a 2-entry valid/ready skid buffer, so decode and execute can stall independently without dropping or duplicating immediates.

## Interface
Parameters:
- IN_W, default 16, immediate field width; must be at least 2.
- OUT_W, default 32, output operand width; must be at least IN_W+2.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset_n, input, 1, **synchronous, active-low reset** (one clock; reset is synchronous and active-low).
- in_valid, input, 1, upstream has a valid immediate this cycle.
- in_ready, output, 1, block can accept this cycle; registered.
- in_imm, input, IN_W, raw immediate field.
- in_mode, input, 2, extension format select (see Operation).
- out_valid, output, 1, out_data holds a valid operand.
- out_ready, input, 1, downstream consumes out_data this cycle.
- out_data, output, OUT_W, extended operand at the buffer head.
- occupancy, output, 2, number of buffered entries (0..2).

## Operation
- Transfers:
  - An input transfer occurs when in_valid and in_ready are both high at a rising edge.
  - An output transfer occurs when out_valid and out_ready are both high at a rising edge.
- Extension is computed combinationally from in_imm and in_mode at accept time. The stored entry is the OUT_W-bit result; mode is not stored.
- Modes:
  - 00 sign-extend: the upper OUT_W-IN_W bits are copies of in_imm[IN_W-1].
  - 01 zero-extend: the upper OUT_W-IN_W bits are 0.
  - 10 upper: in_imm is placed in bits [OUT_W-1:OUT_W-IN_W] and the low bits are 0.
  - 11 branch offset: sign-extend to OUT_W, then shift left by 2. The two MSBs shifted out are discarded and bits [1:0] are 0.
- Buffer: 2-entry FIFO (head and tail registers plus a count).
  - States: EMPTY (count 0), ONE (count 1), FULL (count 2).
  - EMPTY: push goes to ONE; no push stays EMPTY.
  - ONE:
    - push without pop goes to FULL.
    - pop without push goes to EMPTY.
    - push and pop in the same cycle stays ONE, with the new entry becoming the head.
    - neither stays ONE.
  - FULL: pop goes to ONE, with the tail promoted to head. No push is possible because in_ready is 0.
- Outputs:
  - out_valid = (count != 0).
  - out_data = head entry when valid.
  - occupancy = count.
  - in_ready is registered and equals (next count != 2).
- Order is strictly FIFO. An entry is never dropped or duplicated.
- When out_valid is high and out_ready is low, out_data stays stable until it is consumed.
- in_valid high while in_ready is low has no effect. Upstream must hold its data.
- Reset with reset_n low at a rising edge:
  - count returns to 0, and head and tail are cleared to 0.
  - out_valid 0, out_data 0, occupancy 0, in_ready 1 (from the first edge with reset_n low).
  - Any in-flight entries are discarded, and any input transfer in that cycle is ignored.

## Timing
- Latency: an immediate accepted at edge N appears on out_data with out_valid high after edge N (consumable at edge N+1), provided the buffer was empty or the head was popped at edge N.
- Throughput: one operand per cycle with out_ready held high. in_ready stays 1 and occupancy settles at 1.
- Backpressure:
  - With out_ready low, two accepts fill the buffer and in_ready drops after the second accept edge.
  - in_ready rises one cycle after the first pop from FULL. This 1-cycle bubble is expected and permitted.
- No combinational path from out_ready to in_ready, or from in_* to out_*.

## Test plan
Default parameters (IN_W=16, OUT_W=32) unless noted.
- Mode 00: 0xF000 → 0xFFFFF000 and 0x0FFF → 0x00000FFF, each one cycle after accept with out_ready=1.
- Mode 01: 0xF000 → 0x0000F000. Mode 10: 0x1234 → 0x12340000. Mode 11: 0xFFFF → 0xFFFFFFFC and 0x0004 → 0x00000010.
- Backpressure:
  - With out_ready=0, offer A=0x0001, B=0x0002, C=0x0003 in mode 00. A and B are accepted, in_ready=0 from the cycle after B, occupancy=2, and C is held with out_data=0x00000001 stable.
  - Raise out_ready: the outputs are 0x1, 0x2, 0x3 in order, with no loss or duplication.
- Streaming: 100 random back-to-back immediates and modes with out_ready=1. Outputs match a reference model, in_ready stays 1 and occupancy is never 2.
- Simultaneous push and pop at occupancy 1 with random out_ready toggling: order is preserved and occupancy stays within 0..2.
- Reset mid-operation:
  - With occupancy=2, pulse reset_n low for one edge. On the next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1.
  - A subsequent accept of 0x8000 in mode 00 yields 0xFFFF8000.
  - Repeat the suite with IN_W=12, OUT_W=24: 0x800 in mode 00 → 0xFFF800.
